// File: rtl/cxd_pkg.sv
// Shared types and helpers for the CXD status serializer family.
package cxd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFTING = 2'd1,
    DRAINED  = 2'd2
  } soct_state_t;

  localparam int unsigned CXD_SYNC_STAGES = 2;
  localparam int unsigned CXD_MAX_W       = 64;
  localparam int unsigned CXD_IDX_W       = $clog2(CXD_MAX_W);

  // Reverses the low n bits of v; bits at and above n come back as zero.
  function automatic logic [CXD_MAX_W-1:0] bit_reverse(input logic [CXD_MAX_W-1:0] v,
                                                       input int unsigned n);
    logic [CXD_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < CXD_MAX_W; i++) begin
      if (i < n) r[CXD_IDX_W'(i)] = v[CXD_IDX_W'(n - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/cxd_edge_sync.sv
// Multi-flop synchroniser for an idle-high host strobe, with a one-cycle falling-edge pulse.
module cxd_edge_sync
  import cxd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = CXD_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  // Reset to the idle-high level so releasing reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign fall = hist_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cxd_status_shifter.sv
// Latches one of NWORDS status words on an xlat fall and serialises it on sqck falls.
module cxd_status_shifter
  import cxd_pkg::*;
#(
  parameter int unsigned WIDTH       = 17,
  parameter int unsigned NWORDS      = 4,
  parameter int unsigned SYNC_STAGES = CXD_SYNC_STAGES,
  parameter int unsigned SELW        = (NWORDS > 1) ? $clog2(NWORDS) : 1,
  parameter int unsigned CNTW        = $clog2(WIDTH)
) (
  input  logic                    sclk,
  input  logic                    rst_n,
  input  logic                    xlat,
  input  logic                    sqck,
  input  logic [SELW-1:0]         word_sel,
  input  logic                    lsb_first,
  input  logic [NWORDS*WIDTH-1:0] status_words,
  output logic                    out,
  output logic                    busy,
  output logic [CNTW-1:0]         bits_left,
  output logic                    overrun,
  output logic [1:0]              dbg_state
);

  logic load_ev, shift_ev;

  cxd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_xlat_sync (
    .clk (sclk), .rst_n (rst_n), .din (xlat), .fall (load_ev)
  );

  cxd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sqck_sync (
    .clk (sclk), .rst_n (rst_n), .din (sqck), .fall (shift_ev)
  );

  soct_state_t            state_q, state_d;
  logic [WIDTH-1:0]       sr_q, sr_d;
  logic                   out_q, out_d;
  logic [CNTW-1:0]        bits_left_q, bits_left_d;
  logic                   overrun_q, overrun_d;

  logic [WIDTH-1:0]       sel_word, load_word;
  logic [CXD_MAX_W-1:0]   pad_word, rev_word;

  // Out-of-range selects fall through to the all-zero default.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < int'(NWORDS); k++) begin
      if (int'(word_sel) == k) sel_word = status_words[k*WIDTH +: WIDTH];
    end
    pad_word              = '0;
    pad_word[WIDTH-1:0]   = sel_word;
    rev_word              = bit_reverse(pad_word, WIDTH);
    load_word             = lsb_first ? rev_word[WIDTH-1:0] : sel_word;
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A load always wins over a coincident shift.
  always_comb begin
    state_d = state_q;
    if (load_ev) begin
      state_d = SHIFTING;
    end else if (shift_ev && state_q == SHIFTING && bits_left_q == '0) begin
      state_d = DRAINED;
    end
  end

  always_comb begin
    busy      = (state_q == SHIFTING) && (bits_left_q != '0);
    dbg_state = state_q;
  end

  // Shift register keeps the not-yet-presented bits MSB-aligned; out holds the current bit.
  always_comb begin
    sr_d        = sr_q;
    out_d       = out_q;
    bits_left_d = bits_left_q;
    overrun_d   = overrun_q;
    if (load_ev) begin
      out_d       = load_word[WIDTH-1];
      sr_d        = load_word << 1;
      bits_left_d = CNTW'(WIDTH - 1);
      overrun_d   = 1'b0;
    end else if (shift_ev) begin
      unique case (state_q)
        SHIFTING: begin
          if (bits_left_q != '0) begin
            out_d       = sr_q[WIDTH-1];
            sr_d        = sr_q << 1;
            bits_left_d = bits_left_q - CNTW'(1);
          end else begin
            out_d = 1'b0;
          end
        end
        DRAINED: begin
          out_d     = 1'b0;
          overrun_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q        <= '0;
      out_q       <= 1'b0;
      bits_left_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      out_q       <= out_d;
      bits_left_q <= bits_left_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out       = out_q;
  assign bits_left = bits_left_q;
  assign overrun   = overrun_q;

endmodule
